vga_sync_decoder: RTL and testbench



---
 rtl/vga_sync_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: watches active-low hsync/vsync, rebuilds
// video_on/pixel_x/pixel_y two clocks behind the input, measures line and
// frame lengths, and runs a SEARCH/VERIFY/LOCKED lock state machine.
module vga_sync_decoder #(
    parameter int H_DISPLAY   = 640,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int H_TOTAL     = 800,
    parameter int V_DISPLAY   = 480,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk_25mhz,
    input  logic        reset,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [11:0] rgb_in,
    output logic        video_on,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic [11:0] rgb_out,
    output logic        frame_start,
    output logic        locked,
    output logic [10:0] h_total_meas,
    output logic [9:0]  v_total_meas,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    localparam logic [10:0] H_MAX  = 11'h7FF;
    localparam logic [9:0]  L_MAX  = 10'h3FF;
    localparam logic [10:0] H_TOT  = 11'(H_TOTAL);
    localparam logic [9:0]  V_TOT  = 10'(V_TOTAL);
    localparam logic [10:0] H_ACT0 = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_ACT1 = 11'(H_SYNC + H_BACK + H_DISPLAY);
    // Rows are counted from the line after the sync/back-porch lines minus one,
    // because l=0 is the hsync fall at/after the vsync fall.
    localparam logic [9:0]  V_ACT0 = 10'(V_SYNC + V_BACK - 1);
    localparam logic [9:0]  V_ACT1 = 10'(V_SYNC + V_BACK - 1 + V_DISPLAY);
    localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

    logic        hs_q, vs_q;
    logic [10:0] h_cnt_q, h_inc, h_cur;
    logic [9:0]  l_q, l_inc, l_cur;
    logic        h_seen_q, f_seen_q, v_pend_q;
    logic [10:0] h_meas_q;
    logic [9:0]  v_meas_q;
    logic        hfall, vfall, frame_hf, line_bad, timeout, frame_bad;

    state_t      state_q, state_d;
    logic [3:0]  good_q, good_d;
    logic        fbad_q, fbad_d;
    logic [7:0]  err_q, err_d;
    logic        err_inc;

    logic        act0, fs0;
    logic [9:0]  x0, y0;
    logic        vo1_q, fs1_q, vo2_q, fs2_q;
    logic [9:0]  x1_q, y1_q, x2_q, y2_q;
    logic [11:0] rgb1_q, rgb2_q;

    // Input history for fall detection
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            hs_q <= 1'b1;
            vs_q <= 1'b1;
        end else begin
            hs_q <= hsync_in;
            vs_q <= vsync_in;
        end
    end

    assign hfall    = hs_q & ~hsync_in;
    assign vfall    = vs_q & ~vsync_in;
    // A vsync fall arms the frame start; the next hsync fall (possibly the same cycle) is line 0.
    assign frame_hf = hfall & (vfall | v_pend_q);
    assign h_inc    = (h_cnt_q == H_MAX) ? H_MAX : h_cnt_q + 11'd1;
    assign h_cur    = hfall ? 11'd0 : h_inc;
    assign l_inc    = (l_q == L_MAX) ? L_MAX : l_q + 10'd1;
    assign l_cur    = frame_hf ? 10'd0 : (hfall ? l_inc : l_q);
    // Only lines/frames that began on an observed edge are judged.
    assign line_bad  = hfall & h_seen_q & (h_inc != H_TOT);
    assign timeout   = h_seen_q & ~hfall & (h_cnt_q == H_MAX - 11'd1);
    assign frame_bad = vfall & (~f_seen_q | (l_inc != V_TOT));

    // Line/frame counters and length measurement
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            h_cnt_q  <= '0;
            l_q      <= '0;
            h_seen_q <= 1'b0;
            f_seen_q <= 1'b0;
            v_pend_q <= 1'b0;
            h_meas_q <= '0;
            v_meas_q <= '0;
        end else begin
            h_cnt_q  <= h_cur;
            l_q      <= l_cur;
            h_seen_q <= h_seen_q | hfall;
            f_seen_q <= f_seen_q | frame_hf;
            v_pend_q <= frame_hf ? 1'b0 : (v_pend_q | vfall);
            if (hfall && h_seen_q)    h_meas_q <= h_inc;
            if (frame_hf && f_seen_q) v_meas_q <= l_inc;
        end
    end

    // Lock FSM next state, good-frame tally and error accounting
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        fbad_d  = fbad_q;
        err_inc = 1'b0;
        unique case (state_q)
            SEARCH: begin
                if (vfall) begin
                    state_d = VERIFY;
                    good_d  = '0;
                    fbad_d  = 1'b0;
                end
            end
            VERIFY: begin
                if (line_bad || timeout) begin
                    err_inc = 1'b1;
                    good_d  = '0;
                    fbad_d  = 1'b1;
                end
                if (vfall) begin
                    if (frame_bad) begin
                        err_inc = f_seen_q;
                        good_d  = '0;
                    end else if (!fbad_d) begin
                        good_d = good_q + 4'd1;
                        if (good_d == LOCK_N) state_d = LOCKED;
                    end else begin
                        good_d = '0;
                    end
                    fbad_d = 1'b0;
                end
            end
            LOCKED: begin
                if (line_bad || timeout || frame_bad) begin
                    state_d = SEARCH;
                    err_inc = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
        err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    // Lock FSM state register
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            state_q <= SEARCH;
            good_q  <= '0;
            fbad_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            fbad_q  <= fbad_d;
            err_q   <= err_d;
        end
    end

    // Decode the current input cycle; gating on state_d makes a lock decided
    // on a vsync fall apply to that very frame.
    always_comb begin
        act0 = h_seen_q && (f_seen_q || frame_hf) && (state_d == LOCKED) &&
               (h_cur >= H_ACT0) && (h_cur < H_ACT1) &&
               (l_cur >= V_ACT0) && (l_cur < V_ACT1);
        x0   = act0 ? 10'(h_cur - H_ACT0) : 10'd0;
        y0   = act0 ? (l_cur - V_ACT0) : 10'd0;
        fs0  = act0 && (x0 == 10'd0) && (y0 == 10'd0);
    end

    // Two-stage output pipeline (fixed 2-clock latency)
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            vo1_q <= 1'b0; fs1_q <= 1'b0; x1_q <= '0; y1_q <= '0; rgb1_q <= '0;
            vo2_q <= 1'b0; fs2_q <= 1'b0; x2_q <= '0; y2_q <= '0; rgb2_q <= '0;
        end else begin
            vo1_q <= act0;  fs1_q <= fs0;   x1_q <= x0;   y1_q <= y0;   rgb1_q <= rgb_in;
            vo2_q <= vo1_q; fs2_q <= fs1_q; x2_q <= x1_q; y2_q <= y1_q; rgb2_q <= rgb1_q;
        end
    end

    assign video_on     = vo2_q;
    assign pixel_x      = x2_q;
    assign pixel_y      = y2_q;
    assign rgb_out      = rgb2_q;
    assign frame_start  = fs2_q;
    assign locked       = (state_q == LOCKED);
    assign h_total_meas = h_meas_q;
    assign v_total_meas = v_meas_q;
    assign err_count    = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder using a shrunken timing so whole frames fit in
// a short run. A stream generator drives sync/rgb; expected pixel outputs go
// into a queue and are compared two clocks later.
module tb_vga_sync_decoder;
    localparam int HD = 16, HS = 4, HB = 3, HT = 28;
    localparam int VD = 6,  VS = 2, VB = 3, VT = 14;
    localparam int LF = 2;

    logic        clk_25mhz = 1'b0;
    logic        reset, hsync_in, vsync_in;
    logic [11:0] rgb_in;
    logic        video_on, frame_start, locked;
    logic [9:0]  pixel_x, pixel_y, v_total_meas;
    logic [11:0] rgb_out;
    logic [10:0] h_total_meas;
    logic [7:0]  err_count;

    always #5 clk_25mhz = ~clk_25mhz;

    vga_sync_decoder #(
        .H_DISPLAY(HD), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
        .V_DISPLAY(VD), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT),
        .LOCK_FRAMES(LF)
    ) dut (
        .clk_25mhz(clk_25mhz), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .rgb_in(rgb_in), .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .rgb_out(rgb_out), .frame_start(frame_start), .locked(locked),
        .h_total_meas(h_total_meas), .v_total_meas(v_total_meas), .err_count(err_count)
    );

    typedef struct packed {
        logic       vo;
        logic [9:0] x;
        logic [9:0] y;
        logic [11:0] rgb;
        logic       fs;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_fail = 0;
    bit   exp_lk = 1'b0;
    int   tb_h = 0;
    logic prev_hs = 1'b1;
    int   vo_cnt = 0, fs_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // One input cycle: drive, push expectation, clock, then check.
    task automatic tick(input logic hs, input logic vs, input logic act,
                        input int x, input int y, input bit rst);
        exp_t e;
        logic [11:0] rgb;
        rgb = 12'($urandom);
        hsync_in = hs; vsync_in = vs; rgb_in = rgb; reset = rst;
        e = '0;
        if (rst) begin
            exp_lk = 1'b0; tb_h = 0; prev_hs = 1'b1;
            sb.delete();
        end else begin
            if (prev_hs && !hs) tb_h = 0;
            else if (tb_h < 2047) begin
                tb_h++;
                if (tb_h == 2047) exp_lk = 1'b0;
            end
            prev_hs = hs;
            e.vo  = act & exp_lk;
            e.x   = e.vo ? 10'(x) : 10'd0;
            e.y   = e.vo ? 10'(y) : 10'd0;
            e.rgb = rgb;
            e.fs  = e.vo && x == 0 && y == 0;
        end
        sb.push_back(e);
        @(posedge clk_25mhz); #1;
        chk("locked", locked, exp_lk);
        if (rst) begin
            chk("rst_outs", {video_on, pixel_x, pixel_y, rgb_out, frame_start}, 0);
            chk("rst_meas", {h_total_meas, v_total_meas, err_count}, 0);
        end
        if (sb.size() == 2) begin
            e = sb.pop_front();
            chk("pix", {video_on, pixel_x, pixel_y, rgb_out, frame_start}, e);
            vo_cnt += int'(video_on);
            fs_cnt += int'(frame_start);
        end
    endtask

    // One generated frame; long_ln gets one extra clock, rst_ln gets a
    // one-cycle reset in the middle of its active region.
    task automatic frame(input int vtot, input int long_ln, input int rst_ln);
        int hl;
        for (int v = 0; v < vtot; v++) begin
            hl = (v == long_ln) ? HT + 1 : HT;
            for (int h = 0; h < hl; h++) begin
                if (long_ln >= 0 && v == long_ln + 1 && h == 0) exp_lk = 1'b0;
                tick(h >= HS, v >= VS,
                     (h >= HS + HB) && (h < HS + HB + HD) &&
                     (v >= VS + VB - 1) && (v < VS + VB - 1 + VD),
                     h - HS - HB, v - (VS + VB - 1), (v == rst_ln) && (h == HS + HB + 2));
            end
        end
    endtask

    initial begin
        hsync_in = 1'b1; vsync_in = 1'b1; rgb_in = '0; reset = 1'b1;
        repeat (3) tick(1'b1, 1'b1, 1'b0, 0, 0, 1'b1);

        // Acquire: VERIFY at frame 0, good frames at 1 and 2, lock at frame 2 start.
        frame(VT, -1, -1);
        frame(VT, -1, -1);
        exp_lk = 1'b1;
        vo_cnt = 0; fs_cnt = 0;
        frame(VT, -1, -1);
        chk("vo_per_frame", vo_cnt, HD * VD);
        chk("fs_per_frame", fs_cnt, 1);
        frame(VT, -1, -1);
        chk("h_meas", h_total_meas, HT);
        chk("v_meas", v_total_meas, VT);
        chk("err0", err_count, 0);

        // Stretched line drops lock at the following hsync fall.
        vo_cnt = 0;
        frame(VT, 5, -1);
        chk("vo_after_drop", vo_cnt, 2 * HD);
        chk("err_long", err_count, 1);
        chk("h_meas_ok", h_total_meas, HT);
        frame(VT, -1, -1);
        frame(VT, -1, -1);
        exp_lk = 1'b1;
        frame(VT, -1, -1);
        chk("err_relock", err_count, 1);

        // Hsync held high: timeout at h_cnt=2047.
        vo_cnt = 0;
        repeat (2100) tick(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        chk("err_timeout", err_count, 2);
        chk("vo_timeout", vo_cnt, 0);

        // Short frames never lock; one error per judged frame.
        for (int i = 0; i < 4; i++) frame(VT - 1, -1, -1);
        chk("v_meas_short", v_total_meas, VT - 1);
        chk("err_short", err_count, 5);
        chk("h_meas_sat", h_total_meas, HT);

        // Recover, lock, then reset mid-line.
        frame(VT, -1, -1);
        chk("err_last_short", err_count, 6);
        frame(VT, -1, -1);
        exp_lk = 1'b1;
        frame(VT, -1, 5);
        frame(VT, -1, -1);
        frame(VT, -1, -1);
        exp_lk = 1'b1;
        vo_cnt = 0; fs_cnt = 0;
        frame(VT, -1, -1);
        chk("vo_after_rst", vo_cnt, HD * VD);
        chk("fs_after_rst", fs_cnt, 1);
        chk("h_meas_rst", h_total_meas, HT);
        chk("v_meas_rst", v_total_meas, VT);
        chk("err_rst", err_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
